// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data, level counter, almost flags and sticky error flags
module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   level,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DEPTH_W   = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_W   = (ADDRSIZE+1)'(AFULL_MARGIN);
  localparam logic [ADDRSIZE:0] AEMPTY_W  = (ADDRSIZE+1)'(AEMPTY_MARGIN);
  localparam logic [ADDRSIZE:0] PTR_ONE   = (ADDRSIZE+1)'(1);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   free_slots;
  logic                wr_ok;
  logic                rd_ok;

  // Flags decode straight from the registered level, no extra flop stage.
  assign free_slots   = DEPTH_W - level;
  assign wfull        = (level == DEPTH_W);
  assign rempty       = (level == '0);
  assign almost_full  = (free_slots <= AFULL_W);
  assign almost_empty = (level <= AEMPTY_W);

  assign wr_ok = winc && !wfull && !flush;
  assign rd_ok = rinc && !rempty && !flush;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
      if (winc && wfull) begin
        overflow <= 1'b1;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Read port: rdata holds its last value unless a read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (flush) begin
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata <= mem[rptr[ADDRSIZE-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       rvalid;
  logic       wfull;
  logic       rempty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo #(
    .DATASIZE(8), .ADDRSIZE(4), .AFULL_MARGIN(2), .AEMPTY_MARGIN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .rvalid(rvalid), .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cycle(input logic f, input logic w, input logic [7:0] d, input logic r);
    flush = f; winc = w; wdata = d; rinc = r;
    @(posedge clk);
    #1;
    flush = 1'b0; winc = 1'b0; rinc = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rdata, rvalid, wfull, rempty, almost_full, almost_empty, level, overflow, underflow}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdata=%0h rvalid=%0b wfull=%0b rempty=%0b af=%0b ae=%0b level=%0d ovf=%0b unf=%0b required 0 0 0 1 0 1 0 0 0",
               rdata, rvalid, wfull, rempty, almost_full, almost_empty, level, overflow, underflow);
    end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'(i - 1), 1'b0);
      checks++;
      if (level !== 5'(i)) begin
        errors++; $display("FAIL fill_level[%0d]: got %0d required %0d", i, level, i);
      end
      checks++;
      if (almost_full !== (i >= 14)) begin
        errors++; $display("FAIL fill_afull[%0d]: got %0b required %0b", i, almost_full, (i >= 14));
      end
      checks++;
      if (almost_empty !== (i <= 2)) begin
        errors++; $display("FAIL fill_aempty[%0d]: got %0b required %0b", i, almost_empty, (i <= 2));
      end
      checks++;
      if (wfull !== (i == 16) || rempty !== 1'b0) begin
        errors++; $display("FAIL fill_full_empty[%0d]: wfull=%0b rempty=%0b required %0b 0", i, wfull, rempty, (i == 16));
      end
    end
  endtask

  task automatic test_overflow;
    cycle(1'b0, 1'b1, 8'hAA, 1'b1);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd15 || wfull !== 1'b0) begin
      errors++; $display("FAIL ovf_reject: ovf=%0b level=%0d wfull=%0b required 1 15 0", overflow, level, wfull);
    end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h00) begin
      errors++; $display("FAIL ovf_read: rvalid=%0b rdata=%0h required 1 00", rvalid, rdata);
    end
    for (int i = 1; i <= 15; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'(i)) begin
        errors++; $display("FAIL drain[%0d]: rvalid=%0b rdata=%0h required 1 %0h", i, rvalid, rdata, i);
      end
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if (rvalid !== 1'b0 || rempty !== 1'b1 || level !== 5'd0 || rdata !== 8'h0F || overflow !== 1'b1) begin
      errors++; $display("FAIL drain_end: rvalid=%0b rempty=%0b level=%0d rdata=%0h ovf=%0b required 0 1 0 0f 1",
                         rvalid, rempty, level, rdata, overflow);
    end
  endtask

  task automatic test_underflow;
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    checks++;
    if (underflow !== 1'b1 || rvalid !== 1'b0 || level !== 5'd1 || rdata !== 8'h0F) begin
      errors++; $display("FAIL unf_reject: unf=%0b rvalid=%0b level=%0d rdata=%0h required 1 0 1 0f",
                         underflow, rvalid, level, rdata);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h55 || level !== 5'd0) begin
      errors++; $display("FAIL unf_next_read: rvalid=%0b rdata=%0h level=%0d required 1 55 0", rvalid, rdata, level);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] wv;
    logic [7:0] rv;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || level !== 5'd0) begin
      errors++; $display("FAIL wrap_flush: ovf=%0b unf=%0b level=%0d required 0 0 0", overflow, underflow, level);
    end
    wv = 8'h10;
    rv = 8'h10;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, wv, 1'b0);
      wv++;
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, wv, 1'b1);
      wv++;
      checks++;
      if (rvalid !== 1'b1 || rdata !== rv || level !== 5'd4 || wfull !== 1'b0 || rempty !== 1'b0 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
        errors++; $display("FAIL wrap[%0d]: rvalid=%0b rdata=%0h level=%0d flags=%0b%0b%0b%0b required 1 %0h 4 0000",
                           i, rvalid, rdata, level, wfull, rempty, overflow, underflow, rv);
      end
      rv++;
    end
  endtask

  task automatic test_flush;
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'hBB, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (level !== 5'd9 || overflow !== 1'b1 || rdata !== 8'h26) begin
      errors++; $display("FAIL flush_setup: level=%0d ovf=%0b rdata=%0h required 9 1 26", level, overflow, rdata);
    end
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    checks++;
    if (level !== 5'd0 || rempty !== 1'b1 || overflow !== 1'b0 || rvalid !== 1'b0 || rdata !== 8'h26) begin
      errors++; $display("FAIL flush: level=%0d rempty=%0b ovf=%0b rvalid=%0b rdata=%0h required 0 1 0 0 26",
                         level, rempty, overflow, rvalid, rdata);
    end
    cycle(1'b0, 1'b1, 8'h77, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rdata !== 8'h77 || rvalid !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL flush_after: rdata=%0h rvalid=%0b level=%0d required 77 1 0", rdata, rvalid, level);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h99, 1'b1);
    cycle(1'b0, 1'b1, 8'h9A, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (level !== 5'd6 || rdata !== 8'h43) begin
      errors++; $display("FAIL areset_setup: level=%0d rdata=%0h required 6 43", level, rdata);
    end
    cycle(1'b0, 1'b1, 8'h9B, 1'b0);
    checks++;
    if (level !== 5'd7) begin
      errors++; $display("FAIL areset_level7: got %0d required 7", level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdata, rvalid, wfull, rempty, almost_full, almost_empty, level, overflow, underflow}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL areset_immediate: rdata=%0h rvalid=%0b wfull=%0b rempty=%0b af=%0b ae=%0b level=%0d ovf=%0b unf=%0b required 0 0 0 1 0 1 0 0 0",
               rdata, rvalid, wfull, rempty, almost_full, almost_empty, level, overflow, underflow);
    end
    #3 rst_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rdata !== 8'h3C || rvalid !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL areset_resume: rdata=%0h rvalid=%0b level=%0d required 3c 1 0", rdata, rvalid, level);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO buffer: dual-port storage array plus write/read pointer control, occupancy counter, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Next generation of the FIFO storage block, for use when producer and consumer share one clock domain. No clock-domain crossing or Gray-coded pointers. Read data is registered, with a one-cycle read latency.

## Interface
Parameters:
- DATASIZE, 8: word width in bits
- ADDRSIZE, 4: address bits; DEPTH = 2**ADDRSIZE words
- AFULL_MARGIN, 2: almost_full asserts when free slots <= AFULL_MARGIN; legal range 0..DEPTH-1
- AEMPTY_MARGIN, 2: almost_empty asserts when level <= AEMPTY_MARGIN; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO contents and error flags
- winc  in  1  write request
- wdata  in  DATASIZE  write data
- rinc  in  1  read request
- rdata  out  DATASIZE  registered read data
- rvalid  out  1  rdata updated this cycle (one-cycle pulse per accepted read)
- wfull  out  1  level == DEPTH
- rempty  out  1  level == 0
- almost_full  out  1  (DEPTH - level) <= AFULL_MARGIN
- almost_empty  out  1  level <= AEMPTY_MARGIN
- level  out  ADDRSIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Pointers: wptr and rptr, each ADDRSIZE+1 bits. The low ADDRSIZE bits address the array; the MSB is the wrap bit. Both increment modulo 2**(ADDRSIZE+1).
- level is held as a registered counter: +1 on write only, -1 on read only, unchanged when both are accepted or neither is. It must always equal wptr - rptr (modulo 2**(ADDRSIZE+1)).
- wr_ok = winc && !wfull. rd_ok = rinc && !rempty. Both are evaluated against the state at the start of the cycle.
- Accepted write: mem[wptr[ADDRSIZE-1:0]] <= wdata; wptr increments.
- Accepted read: rdata <= mem[rptr[ADDRSIZE-1:0]]; rvalid <= 1; rptr increments. Otherwise rvalid <= 0 and rdata holds its value.
- Rejected write (winc && wfull): nothing is stored, and overflow is set. This also applies when rinc is active in the same cycle: there is no same-cycle pass-through when full.
- Rejected read (rinc && rempty): rdata is unchanged, rvalid = 0, and underflow is set. This also applies when winc is active in the same cycle; the write is still accepted.
- Simultaneous accepted read and write: both are performed, and level is unchanged. The addresses can never collide, because the FIFO is neither empty nor full, so no bypass logic is required.
- overflow and underflow stay set until flush or reset.
- flush has priority over winc and rinc in the same cycle. It sets wptr = rptr = 0, level = 0, overflow = underflow = 0 and rvalid = 0. rdata is unchanged and array contents are not cleared.
- wfull, rempty, almost_full and almost_empty are decoded combinationally from the registered level. There are no extra flop stages on these flags.
- Array storage has no reset.

## Timing
- Reset values: rdata = 0, rvalid = 0, wfull = 0, rempty = 1, almost_full = 0 (when AFULL_MARGIN < DEPTH), almost_empty = 1, level = 0, overflow = 0, underflow = 0. Pointers reset to 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronous). Operation resumes on the first rising edge after rst_n deasserts.
- Write latency: a write accepted at edge k updates level, rempty and the almost flags in the cycle after edge k. That data becomes readable by a rinc sampled at edge k+1.
- Read latency: rinc accepted at edge k gives rdata/rvalid valid after edge k, for one cycle. Back-to-back reads give one word per cycle.
- Flags update on the same edge as level, so a full FIFO drops wfull in the cycle after the first accepted read.
- Sustained throughput is one write and one read per cycle.

## Test plan
- Fill from empty, DEPTH=16: 16 consecutive writes of 0x00..0x0F. After the 16th edge, wfull=1 and level=16. almost_full rises after write 14 (level=14). almost_empty falls after write 3 (level=3).
- Write 0xAA while full, with rinc=1 in the same cycle: write rejected, overflow=1, level=15. Draining then returns 0x01..0x0F, and 0xAA never appears.
- Read while empty with winc=1 and wdata=0x55: underflow=1, rvalid=0, level=1. The next read returns 0x55 with rvalid=1.
- Wrap-around: 40 cycles of simultaneous write/read at level 4 with an incrementing pattern. Data emerges in order, level stays 4, and no flags are set.
- flush at level 9 with overflow=1, and winc=rinc=1 in the same cycle: next cycle shows level=0, rempty=1, overflow=0, rvalid=0, with rdata unchanged. The write is discarded.
- rst_n pulsed low asynchronously (between edges) at level 7: all outputs take their reset values immediately. After release, a write then a read returns the new word.
